// File: rtl/rx_frame_sched.sv
// rx_frame_sched
//   RX frame store controller. Parser words are written straight into an
//   external 2^ADDR_W x 16 dual-port RAM. Frames failing checksum, aborted by
//   a new sof, over-length, or arriving while the store or the descriptor FIFO
//   is full are rolled back. Committed frames queue as {start,len}
//   descriptors and are streamed out frame-by-frame with valid/ready.
//
//   Parameters: ADDR_W (RAM address width), DESC_DEPTH (descriptor FIFO
//   entries, power of 2).
//   Optional build macro RX_STATS_EN adds saturating counters stat_good,
//   stat_bad and stat_drop.
//
//   Ports:
//     clock, reset                  rising-edge clock, async active-high reset
//     wr_valid/wr_data/wr_sof/wr_eof/crc_ok   parser write side
//     ram_we/ram_waddr/ram_wdata    RAM write port (combinational from wr_*)
//     ram_re/ram_raddr/ram_rdata    RAM read port (data one cycle after re)
//     out_valid/out_data/out_sof/out_eof/out_ready   output stream
//     frame_bad, frame_drop         one-cycle discard pulses
//     frames_pending                descriptors queued
module rx_frame_sched #(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned DESC_DEPTH = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        wr_valid,
  input  logic [15:0]                 wr_data,
  input  logic                        wr_sof,
  input  logic                        wr_eof,
  input  logic                        crc_ok,
  output logic                        ram_we,
  output logic [ADDR_W-1:0]           ram_waddr,
  output logic [15:0]                 ram_wdata,
  output logic                        ram_re,
  output logic [ADDR_W-1:0]           ram_raddr,
  input  logic [15:0]                 ram_rdata,
  output logic                        out_valid,
  output logic [15:0]                 out_data,
  output logic                        out_sof,
  output logic                        out_eof,
  input  logic                        out_ready,
  output logic                        frame_bad,
  output logic                        frame_drop,
  output logic [$clog2(DESC_DEPTH):0] frames_pending
`ifdef RX_STATS_EN
  ,
  output logic [15:0]                 stat_good,
  output logic [15:0]                 stat_bad,
  output logic [15:0]                 stat_drop
`endif
);

  localparam int unsigned DW = $clog2(DESC_DEPTH);
  localparam logic [ADDR_W:0]   STORE_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_P       = 1;
  localparam logic [ADDR_W-1:0] ONE_A       = 1;
  localparam logic [ADDR_W-1:0] LEN_MAX     = '1;
  localparam logic [DW:0]       D_FULL      = {1'b1, {DW{1'b0}}};
  localparam logic [DW:0]       ONE_D       = 1;

  typedef enum logic [1:0] {W_IDLE, W_FRAME, W_DROP} w_state_t;
  typedef enum logic       {R_IDLE, R_STREAM}        r_state_t;

  // ---------------- write side ----------------
  w_state_t          w_state, w_next;
  logic [ADDR_W:0]   wptr, cptr, fptr, wptr_n, cptr_n, waddr_p;
  logic [ADDR_W:0]   wfill, cfill;
  logic [ADDR_W-1:0] start, start_n, wlen, wlen_n;
  logic [ADDR_W-1:0] push_start, push_len;
  logic              push, open, desc_full, desc_empty;

  assign wfill = wptr - fptr;
  assign cfill = cptr - fptr;

  always_comb begin
    w_next     = w_state;
    wptr_n     = wptr;
    cptr_n     = cptr;
    start_n    = start;
    wlen_n     = wlen;
    waddr_p    = wptr;
    ram_we     = 1'b0;
    push       = 1'b0;
    push_start = start;
    push_len   = wlen + ONE_A;
    frame_bad  = 1'b0;
    frame_drop = 1'b0;
    open       = 1'b0;
    unique case (w_state)
      W_IDLE: open = wr_valid && wr_sof;
      W_FRAME: begin
        if (wr_valid) begin
          if (wr_sof) begin
            frame_bad = 1'b1;
            wptr_n    = cptr;
            open      = 1'b1;
          end else if (wfill == STORE_WORDS || wlen == LEN_MAX) begin
            wptr_n     = cptr;
            frame_drop = 1'b1;
            w_next     = wr_eof ? W_IDLE : W_DROP;
          end else begin
            ram_we  = 1'b1;
            wptr_n  = wptr + ONE_P;
            wlen_n  = wlen + ONE_A;
            if (wr_eof) begin
              w_next = W_IDLE;
              if (crc_ok) begin
                push   = 1'b1;
                cptr_n = wptr + ONE_P;
              end else begin
                frame_bad = 1'b1;
                wptr_n    = cptr;
              end
            end
          end
        end
      end
      W_DROP: if (wr_valid && wr_eof) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
    // A new frame always opens at the commit pointer; this also covers the
    // abort-and-restart case where wptr is being rolled back this cycle.
    if (open) begin
      if (desc_full || cfill == STORE_WORDS) begin
        frame_drop = 1'b1;
        wptr_n     = cptr;
        w_next     = wr_eof ? W_IDLE : W_DROP;
      end else begin
        ram_we  = 1'b1;
        waddr_p = cptr;
        start_n = cptr[ADDR_W-1:0];
        wlen_n  = ONE_A;
        wptr_n  = cptr + ONE_P;
        w_next  = W_FRAME;
        if (wr_eof) begin
          w_next = W_IDLE;
          if (crc_ok) begin
            push       = 1'b1;
            push_start = cptr[ADDR_W-1:0];
            push_len   = ONE_A;
            cptr_n     = cptr + ONE_P;
          end else begin
            frame_bad = 1'b1;
            wptr_n    = cptr;
          end
        end
      end
    end
  end

  assign ram_waddr = waddr_p[ADDR_W-1:0];
  assign ram_wdata = ram_we ? wr_data : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_state <= W_IDLE;
      wptr    <= '0;
      cptr    <= '0;
      start   <= '0;
      wlen    <= '0;
    end else begin
      w_state <= w_next;
      wptr    <= wptr_n;
      cptr    <= cptr_n;
      start   <= start_n;
      wlen    <= wlen_n;
    end
  end

  // ---------------- descriptor FIFO ----------------
  logic [ADDR_W-1:0] d_start [DESC_DEPTH];
  logic [ADDR_W-1:0] d_len   [DESC_DEPTH];
  logic [DW:0]       d_wp, d_rp, d_count;
  logic              pop;

  assign d_count        = d_wp - d_rp;
  assign desc_full      = (d_count == D_FULL);
  assign desc_empty     = (d_count == '0);
  assign frames_pending = d_count;

  always_ff @(posedge clock) begin
    if (push) begin
      d_start[d_wp[DW-1:0]] <= push_start;
      d_len[d_wp[DW-1:0]]   <= push_len;
    end
  end

  // ---------------- read side ----------------
  r_state_t          r_state;
  logic [ADDR_W-1:0] raddr, rem;
  logic              first, rd_pend, rd_sof, rd_eof, last_issue, issue_ok;
  logic [1:0]        occ, occ_pop;
  logic [15:0]       sk_data0, sk_data1;
  logic              sk_sof0, sk_sof1, sk_eof0, sk_eof1;
  logic              accept, take_head, store_in;

  // Skid entries plus the word in flight from the RAM never exceed two.
  assign issue_ok   = ({1'b0, occ} + {2'b00, rd_pend}) < 3'd2;
  assign ram_re     = (r_state == R_STREAM) && issue_ok;
  assign last_issue = ram_re && (rem == ONE_A);
  // The next descriptor pops in the same cycle the previous frame's last
  // word issues, so back-to-back frames stream without a bubble.
  assign pop        = !desc_empty && ((r_state == R_IDLE) || last_issue);
  assign ram_raddr  = raddr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= R_IDLE;
      raddr   <= '0;
      rem     <= '0;
      first   <= 1'b0;
      fptr    <= '0;
      d_wp    <= '0;
      d_rp    <= '0;
      rd_pend <= 1'b0;
      rd_sof  <= 1'b0;
      rd_eof  <= 1'b0;
    end else begin
      if (push) d_wp <= d_wp + ONE_D;
      if (pop)  d_rp <= d_rp + ONE_D;
      if (pop) begin
        r_state <= R_STREAM;
        raddr   <= d_start[d_rp[DW-1:0]];
        rem     <= d_len[d_rp[DW-1:0]];
        first   <= 1'b1;
      end else if (ram_re) begin
        raddr   <= raddr + ONE_A;
        rem     <= rem - ONE_A;
        first   <= 1'b0;
        if (last_issue) r_state <= R_IDLE;
      end
      if (ram_re) fptr <= fptr + ONE_P;
      rd_pend <= ram_re;
      rd_sof  <= ram_re && first;
      rd_eof  <= last_issue;
    end
  end

  // Output is taken from the skid head, or straight from the RAM when the
  // skid is empty; an unaccepted word is parked in the skid so it stays stable.
  always_comb begin
    out_valid = (occ != 2'd0) || rd_pend;
    out_data  = '0;
    out_sof   = 1'b0;
    out_eof   = 1'b0;
    if (occ != 2'd0) begin
      out_data = sk_data0;
      out_sof  = sk_sof0;
      out_eof  = sk_eof0;
    end else if (rd_pend) begin
      out_data = ram_rdata;
      out_sof  = rd_sof;
      out_eof  = rd_eof;
    end
  end

  assign accept    = out_valid && out_ready;
  assign take_head = accept && (occ != 2'd0);
  assign store_in  = rd_pend && !(accept && (occ == 2'd0));
  assign occ_pop   = occ - {1'b0, take_head};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occ      <= '0;
      sk_data0 <= '0;
      sk_data1 <= '0;
      sk_sof0  <= 1'b0;
      sk_sof1  <= 1'b0;
      sk_eof0  <= 1'b0;
      sk_eof1  <= 1'b0;
    end else begin
      if (take_head) begin
        sk_data0 <= sk_data1;
        sk_sof0  <= sk_sof1;
        sk_eof0  <= sk_eof1;
      end
      if (store_in) begin
        if (occ_pop == 2'd0) begin
          sk_data0 <= ram_rdata;
          sk_sof0  <= rd_sof;
          sk_eof0  <= rd_eof;
        end else begin
          sk_data1 <= ram_rdata;
          sk_sof1  <= rd_sof;
          sk_eof1  <= rd_eof;
        end
      end
      occ <= occ_pop + {1'b0, store_in};
    end
  end

`ifdef RX_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_good <= '0;
      stat_bad  <= '0;
      stat_drop <= '0;
    end else begin
      if (push && stat_good != 16'hFFFF)       stat_good <= stat_good + 16'd1;
      if (frame_bad && stat_bad != 16'hFFFF)   stat_bad  <= stat_bad + 16'd1;
      if (frame_drop && stat_drop != 16'hFFFF) stat_drop <= stat_drop + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rx_frame_sched.sv
// tb_rx_frame_sched
//   Self-checking bench for rx_frame_sched built with ADDR_W=6 (64-word
//   store) and DESC_DEPTH=16, driving a behavioural dual-port RAM.
module tb_rx_frame_sched;

  localparam int AW = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic          wr_valid, wr_sof, wr_eof, crc_ok;
  logic [15:0]   wr_data;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [15:0]   ram_wdata;
  logic [15:0]   ram_rdata = '0;
  logic          out_valid, out_sof, out_eof;
  logic [15:0]   out_data;
  logic          out_ready = 1'b1;
  logic          frame_bad, frame_drop;
  logic [4:0]    frames_pending;

  rx_frame_sched #(.ADDR_W(AW), .DESC_DEPTH(16)) dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_sof(wr_sof), .wr_eof(wr_eof), .crc_ok(crc_ok),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
    .out_ready(out_ready), .frame_bad(frame_bad), .frame_drop(frame_drop),
    .frames_pending(frames_pending)
  );

  always #5 clock = ~clock;

  logic [15:0] mem [64];
  always @(posedge clock) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_raddr];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // out_ready: 0 = low, 1 = high, 2 = toggle every cycle
  int rdy_mode = 1;
  initial forever begin
    @(posedge clock); #1;
    out_ready = (rdy_mode == 2) ? ~out_ready : (rdy_mode == 1);
  end

  // Output scoreboard: expected {sof,eof,data}, plus hold-stability check.
  logic [17:0] exp_q [$];
  bit          mon_en = 1'b0;
  bit          hold_v = 1'b0;
  logic [18:0] hold_word;
  always @(negedge clock) begin
    if (mon_en) begin
      if (hold_v) chk("out_stable", {out_valid, out_sof, out_eof, out_data}, hold_word);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%0h required=none", {out_sof, out_eof, out_data});
        end else begin
          chk("out_word", {out_sof, out_eof, out_data}, exp_q.pop_front());
        end
      end
      hold_v    = out_valid && !out_ready;
      hold_word = {out_valid, out_sof, out_eof, out_data};
    end else begin
      hold_v = 1'b0;
    end
  end

  int mw = 0;   // model commit pointer (RAM address of next frame)

  task automatic idle_inputs();
    wr_valid = 1'b0; wr_sof = 1'b0; wr_eof = 1'b0; crc_ok = 1'b0; wr_data = '0;
  endtask

  task automatic send_frame(input int n, input logic [15:0] base, input logic crc);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      wr_valid = 1'b1; wr_sof = (i == 0); wr_eof = (i == n - 1);
      crc_ok = crc; wr_data = base + 16'(i);
      @(negedge clock);
      chk("wr_we", ram_we, 1);
      chk("wr_addr", ram_waddr, (mw + i) % 64);
      if (i == n - 1) chk("wr_bad", frame_bad, !crc);
      if (crc) exp_q.push_back({(i == 0), (i == n - 1), base + 16'(i)});
    end
    @(posedge clock); #1;
    idle_inputs();
    if (crc) mw = (mw + n) % 64;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid || frames_pending != 0) && n < 500) begin
      @(negedge clock);
      n++;
    end
    chk("drain", (exp_q.size() == 0 && !out_valid && frames_pending == 0), 1);
    repeat (2) @(posedge clock);
  endtask

  task automatic chk_zero_outputs();
    chk("z_ram_we", ram_we, 0);
    chk("z_ram_waddr", ram_waddr, 0);
    chk("z_ram_wdata", ram_wdata, 0);
    chk("z_ram_re", ram_re, 0);
    chk("z_ram_raddr", ram_raddr, 0);
    chk("z_out", {out_valid, out_sof, out_eof, out_data}, 0);
    chk("z_pulses", {frame_bad, frame_drop}, 0);
    chk("z_pending", frames_pending, 0);
  endtask

  // Write-side vectors: ctl = {valid,sof,eof,crc_ok}; ex = {ram_we,frame_bad,frame_drop}
  typedef struct packed {
    logic [3:0]  ctl;
    logic [15:0] data;
    logic [2:0]  ex;
    logic [5:0]  addr;
  } vec_t;

  vec_t tbl [21];
  logic [17:0] tbl_out [10];

  initial begin
    tbl = '{
      '{4'b1101, 16'h1111, 3'b100, 6'd0},   // good 4-word frame at 0..3
      '{4'b1001, 16'h2222, 3'b100, 6'd1},
      '{4'b1001, 16'h3333, 3'b100, 6'd2},
      '{4'b1011, 16'h4444, 3'b100, 6'd3},
      '{4'b0000, 16'h0000, 3'b000, 6'd0},
      '{4'b1001, 16'h9999, 3'b000, 6'd0},   // no sof while idle: ignored
      '{4'b1100, 16'hAAAA, 3'b100, 6'd4},   // crc-bad frame 4..7
      '{4'b1000, 16'hBBBB, 3'b100, 6'd5},
      '{4'b1000, 16'hCCCC, 3'b100, 6'd6},
      '{4'b1010, 16'hDDDD, 3'b110, 6'd7},
      '{4'b1101, 16'h5555, 3'b100, 6'd4},   // rolled back: 2-word frame at 4
      '{4'b0001, 16'h0000, 3'b000, 6'd0},
      '{4'b1011, 16'h6666, 3'b100, 6'd5},
      '{4'b1101, 16'h7001, 3'b100, 6'd6},   // 3 words then sof without eof
      '{4'b1001, 16'h7002, 3'b100, 6'd7},
      '{4'b1001, 16'h7003, 3'b100, 6'd8},
      '{4'b1101, 16'h8001, 3'b110, 6'd6},   // abort, restart from commit pointer
      '{4'b1011, 16'h8002, 3'b100, 6'd7},
      '{4'b1111, 16'h0A01, 3'b100, 6'd8},   // 1-word frames
      '{4'b1110, 16'h0A02, 3'b110, 6'd9},
      '{4'b1111, 16'h0A03, 3'b100, 6'd9}
    };
    tbl_out = '{
      {2'b10, 16'h1111}, {2'b00, 16'h2222}, {2'b00, 16'h3333}, {2'b01, 16'h4444},
      {2'b10, 16'h5555}, {2'b01, 16'h6666},
      {2'b10, 16'h8001}, {2'b01, 16'h8002},
      {2'b11, 16'h0A01}, {2'b11, 16'h0A03}
    };

    idle_inputs();
    reset = 1'b1;
    #12;
    chk_zero_outputs();
    @(posedge clock); #1;
    reset = 1'b0;
    mon_en = 1'b1;

    // Table-driven write sequence with out_ready high
    for (int i = 0; i < 10; i++) exp_q.push_back(tbl_out[i]);
    for (int i = 0; i < 21; i++) begin
      @(posedge clock); #1;
      {wr_valid, wr_sof, wr_eof, crc_ok} = tbl[i].ctl;
      wr_data = tbl[i].data;
      @(negedge clock);
      chk("tbl_we", ram_we, tbl[i].ex[2]);
      if (tbl[i].ex[2]) chk("tbl_addr", ram_waddr, tbl[i].addr);
      chk("tbl_bad", frame_bad, tbl[i].ex[1]);
      chk("tbl_drop", frame_drop, tbl[i].ex[0]);
    end
    @(posedge clock); #1;
    idle_inputs();
    mw = 10;
    wait_drain();

    // 8-word frame with out_ready toggling each cycle
    rdy_mode = 2;
    send_frame(8, 16'hC000, 1'b1);
    wait_drain();
    rdy_mode = 1;

    // Eight 10-word frames: write address wraps 63 -> 0
    for (int f = 0; f < 8; f++) send_frame(10, 16'hD000 + 16'(f * 16), 1'b1);
    wait_drain();

    // Over-length: 64th word would make len 64 > 63 -> drop, no further writes
    for (int i = 0; i < 65; i++) begin
      @(posedge clock); #1;
      wr_valid = 1'b1; wr_sof = (i == 0); wr_eof = (i == 64);
      crc_ok = 1'b1; wr_data = 16'h5000 + 16'(i);
      @(negedge clock);
      if (i < 63) begin
        chk("ovl_we", ram_we, 1);
        chk("ovl_addr", ram_waddr, (mw + i) % 64);
        chk("ovl_drop", frame_drop, 0);
      end else begin
        chk("ovl_we_off", ram_we, 0);
        chk("ovl_drop_edge", frame_drop, (i == 63));
      end
    end
    @(posedge clock); #1;
    idle_inputs();
    send_frame(2, 16'hE000, 1'b1);
    wait_drain();

    // Descriptor FIFO full with out_ready low. Two frames sit in the output
    // skid and a third is held by the reader, so the FIFO fills on frame 19.
    rdy_mode = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock); #1;
      wr_valid = 1'b1; wr_sof = 1'b1; wr_eof = 1'b1; crc_ok = 1'b1;
      wr_data = 16'hF000 + 16'(k);
      @(negedge clock);
      if (k <= 19) begin
        chk("ff_we", ram_we, 1);
        chk("ff_addr", ram_waddr, mw);
        chk("ff_drop", frame_drop, 0);
        exp_q.push_back({2'b11, 16'hF000 + 16'(k)});
        mw = (mw + 1) % 64;
      end else begin
        chk("ff_full_we", ram_we, 0);
        chk("ff_full_drop", frame_drop, 1);
      end
      @(posedge clock); #1;
      idle_inputs();
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("ff_pending", frames_pending, (k <= 3) ? 0 : ((k > 19 ? 19 : k) - 3));
    end
    rdy_mode = 1;
    wait_drain();

    // Reset mid-stream with a second frame half-written
    send_frame(12, 16'hB000, 1'b1);
    @(posedge clock); #1;
    wr_valid = 1'b1; wr_sof = 1'b1; wr_eof = 1'b0; crc_ok = 1'b1; wr_data = 16'h6001;
    @(posedge clock); #1;
    wr_sof = 1'b0; wr_data = 16'h6002;
    @(negedge clock);
    chk("pre_rst_streaming", out_valid, 1);
    mon_en = 1'b0;
    #2 reset = 1'b1;
    #1 chk_zero_outputs();
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    wr_eof = 1'b1; wr_data = 16'h6003;
    @(negedge clock);
    chk("post_rst_ignore", ram_we, 0);
    @(posedge clock); #1;
    idle_inputs();
    mw = 0;
    send_frame(3, 16'h3000, 1'b1);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
